// File: rtl/key_event_if.sv
// Key sample / key event bundle between the debouncer side and the event decoder.
// The decoder takes the slave modport; the sample source takes the master modport.
interface key_event_if;
  logic       key_stb;
  logic [7:0] key_val;
  logic [7:0] key_press;
  logic [7:0] key_release;
  logic [7:0] key_hold;
  logic [7:0] key_repeat;

  modport master (
    output key_stb, key_val,
    input  key_press, key_release, key_hold, key_repeat
  );

  modport slave (
    input  key_stb, key_val,
    output key_press, key_release, key_hold, key_repeat
  );
endinterface

// File: rtl/key_event_decoder.sv
// Turns debounced 8-key samples into press/release pulses, a long-press level and
// auto-repeat pulses; all timing is counted in sample strobes.
module key_event_decoder #(
  parameter int ACTIVE_LOW     = 1,
  parameter int LONG_SAMPLES   = 50,
  parameter int REPEAT_SAMPLES = 10
) (
  input logic        CLK_50M,
  input logic        RST_N,
  key_event_if.slave kif
);

  // Bit 0 = key down, bit 1 = long-press; 2'b10 never occurs.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PRESS = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b11;

  localparam logic [8:0] LONG_CNT   = 9'(LONG_SAMPLES);
  localparam logic [8:0] REPEAT_CNT = 9'(REPEAT_SAMPLES);

  logic [7:0] pressed;
  assign pressed = (ACTIVE_LOW != 0) ? ~kif.key_val : kif.key_val;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_key
      logic [1:0] st_q, st_d;
      logic [7:0] cnt_q, cnt_d;
      logic       press_q, press_d;
      logic       release_q, release_d;
      logic       repeat_q, repeat_d;
      logic [8:0] cnt_inc;

      assign cnt_inc = {1'b0, cnt_q} + 9'd1;

      always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        if (kif.key_stb) begin
          case (st_q)
            ST_PRESS: begin
              if (!pressed[gi]) begin
                st_d      = ST_IDLE;
                cnt_d     = 8'd0;
                release_d = 1'b1;
              end else if (cnt_inc == LONG_CNT) begin
                st_d     = ST_HOLD;
                cnt_d    = 8'd0;
                repeat_d = 1'b1;
              end else begin
                cnt_d = cnt_inc[7:0];
              end
            end
            ST_HOLD: begin
              if (!pressed[gi]) begin
                st_d      = ST_IDLE;
                cnt_d     = 8'd0;
                release_d = 1'b1;
              end else if (cnt_inc == REPEAT_CNT) begin
                cnt_d    = 8'd0;
                repeat_d = 1'b1;
              end else begin
                cnt_d = cnt_inc[7:0];
              end
            end
            default: begin
              if (pressed[gi]) begin
                st_d    = ST_PRESS;
                cnt_d   = 8'd0;
                press_d = 1'b1;
              end
            end
          endcase
        end
      end

      always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
          st_q      <= ST_IDLE;
          cnt_q     <= 8'd0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          repeat_q  <= 1'b0;
        end else begin
          st_q      <= st_d;
          cnt_q     <= cnt_d;
          press_q   <= press_d;
          release_q <= release_d;
          repeat_q  <= repeat_d;
        end
      end

      assign kif.key_press[gi]   = press_q;
      assign kif.key_release[gi] = release_q;
      assign kif.key_repeat[gi]  = repeat_q;
      assign kif.key_hold[gi]    = st_q[1];
    end
  endgenerate

endmodule
